// File: rtl/alu32.sv
// Registered integer ALU: the result of r2 <aop> r3 and its status flags land
// in r1/zf/nf/cf/vf on the clock edge after they are sampled with en=1.
module alu32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] r2,
    input  logic [WIDTH-1:0] r3,
    input  logic [2:0]       aop,
    output logic [WIDTH-1:0] r1,
    output logic             zf,
    output logic             nf,
    output logic             cf,
    output logic             vf
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_SLT = 3'd7;

    // No handshake: en=1 captures a new result at the edge, en=0 holds every output.
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH:0]   sll_w;
    logic [WIDTH:0]   srl_w;
    logic [WIDTH-1:0] res;
    logic             c_nxt;
    logic             v_nxt;

    assign shamt = r3[SHW-1:0];
    assign add_w = {1'b0, r2} + {1'b0, r3};
    assign sub_w = {1'b0, r2} - {1'b0, r3};
    // One extra bit on the exit side of each shifter catches the last bit shifted out.
    assign sll_w = {1'b0, r2} << shamt;
    assign srl_w = {r2, 1'b0} >> shamt;

    always_comb begin
        res   = '0;
        c_nxt = 1'b0;
        v_nxt = 1'b0;
        case (aop)
            OP_ADD: begin
                res   = add_w[WIDTH-1:0];
                c_nxt = add_w[WIDTH];
                v_nxt = (r2[WIDTH-1] == r3[WIDTH-1]) && (res[WIDTH-1] != r2[WIDTH-1]);
            end
            OP_SUB: begin
                res   = sub_w[WIDTH-1:0];
                c_nxt = sub_w[WIDTH];
                v_nxt = (r2[WIDTH-1] != r3[WIDTH-1]) && (res[WIDTH-1] != r2[WIDTH-1]);
            end
            OP_AND: res = r2 & r3;
            OP_OR:  res = r2 | r3;
            OP_XOR: res = r2 ^ r3;
            OP_SLL: begin
                res   = sll_w[WIDTH-1:0];
                c_nxt = sll_w[WIDTH];
            end
            OP_SRL: begin
                res   = srl_w[WIDTH:1];
                c_nxt = srl_w[0];
            end
            OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(r2) < $signed(r3))};
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1 <= '0;
            zf <= 1'b0;
            nf <= 1'b0;
            cf <= 1'b0;
            vf <= 1'b0;
        end else if (en) begin
            r1 <= res;
            zf <= (res == '0);
            nf <= res[WIDTH-1];
            cf <= c_nxt;
            vf <= v_nxt;
        end
    end

endmodule

// File: tb/tb_alu32.sv
// Bench for alu32: directed cases, hold/async-reset behaviour and randomized
// back-to-back traffic compared with an arithmetic reference model.
module tb_alu32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [31:0] r2  = '0;
    logic [31:0] r3  = '0;
    logic [2:0]  aop = '0;
    logic [31:0] r1;
    logic        zf, nf, cf, vf;

    int vectors    = 0;
    int miscompares = 0;
    logic [35:0] exp_q[$];

    alu32 #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .en(en), .r2(r2), .r3(r3), .aop(aop),
        .r1(r1), .zf(zf), .nf(nf), .cf(cf), .vf(vf)
    );

    // clock/reset block
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Reference model: {r1, zf, nf, cf, vf} from plain 64-bit integer arithmetic.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
        longint      ua, ub, sa, sb, s, lo, hi;
        logic [31:0] r;
        logic        c, v;
        int unsigned n;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = (longint'(1) << 31) - 1;
        lo = -(longint'(1) << 31);
        n  = int'(b % 32);
        r = '0; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: begin
                s = ua + ub; r = s[31:0]; c = (s > longint'(32'hFFFF_FFFF));
                s = sa + sb; v = (s > hi) || (s < lo);
            end
            3'd1: begin
                s = ua - ub; r = s[31:0]; c = (ua < ub);
                s = sa - sb; v = (s > hi) || (s < lo);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin
                s = ua << n; r = s[31:0];
                c = (n != 0) ? s[32] : 1'b0;
            end
            3'd6: begin
                r = a >> n;
                c = (n != 0) ? ((ua >> (n - 1)) & 1) != 0 : 1'b0;
            end
            default: r = (sa < sb) ? 32'd1 : 32'd0;
        endcase
        return {r, (r == 32'd0), r[31], c, v};
    endfunction

    // driver: present inputs, let one rising edge pass, land 1 time unit after it
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic e);
        r2 = a; r3 = b; aop = op; en = e;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; r2 = 32'd5; r3 = 32'd3; aop = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({r1, zf, nf, cf, vf} !== 36'd0) begin
            miscompares++;
            $display("FAIL reset_hold: got r1=%h flags=%b%b%b%b, required all zero",
                     r1, zf, nf, cf, vf);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (r1 !== 32'd8 || zf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: got r1=%h zf=%b, required r1=00000008 zf=0", r1, zf);
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta[15];
        logic [31:0] tb_[15];
        logic [2:0]  top[15];
        logic [35:0] texp[15];
        ta  = '{32'h0, 32'h0, 32'h0, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
                32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'h8000_0001, 32'h8000_0001,
                32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h1234_5678, 32'hDEAD_BEEF};
        tb_ = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h1,
                32'h0FF0_0FF0, 32'h0FF0_0FF0, 32'h0FF0_0FF0, 32'h21, 32'h21,
                32'h0, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFE0, 32'h0000_0040};
        top = '{3'd0, 3'd7, 3'd1, 3'd0, 3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6,
                3'd7, 3'd7, 3'd1, 3'd5, 3'd6};
        // {r1, zf, nf, cf, vf} worked out by hand from the opcode rules
        texp = '{{32'h1, 4'b0000}, {32'h1, 4'b0000}, {32'hFFFF_FFFF, 4'b0110},
                 {32'h8000_0000, 4'b0101}, {32'h0, 4'b1010},
                 {32'h00F0_00F0, 4'b0000}, {32'hFFF0_FFF0, 4'b0100}, {32'hFF00_FF00, 4'b0100},
                 {32'h0000_0002, 4'b0010}, {32'h4000_0000, 4'b0010},
                 {32'h1, 4'b0000}, {32'h0, 4'b1000},
                 {32'h7FFF_FFFF, 4'b0001}, {32'h1234_5678, 4'b0000}, {32'hDEAD_BEEF, 4'b0100}};
        for (int i = 0; i < 15; i++) begin
            drive(ta[i], tb_[i], top[i], 1'b1);
            vectors++;
            if ({r1, zf, nf, cf, vf} !== texp[i]) begin
                miscompares++;
                $display("FAIL directed[%0d]: got r1=%h zncv=%b%b%b%b, required r1=%h zncv=%b",
                         i, r1, zf, nf, cf, vf, texp[i][35:4], texp[i][3:0]);
            end
        end
    endtask

    task automatic test_hold_async_reset();
        drive(32'h0, 32'h1, 3'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive($urandom, $urandom, 3'($urandom_range(0, 7)), 1'b0);
            vectors++;
            if ({r1, zf, nf, cf, vf} !== {32'h1, 4'b0000}) begin
                miscompares++;
                $display("FAIL hold[%0d]: got r1=%h zncv=%b%b%b%b, required r1=00000001 zncv=0000",
                         i, r1, zf, nf, cf, vf);
            end
        end
        // pulse rst between edges; the outputs must clear before the next edge
        en = 1'b1; r2 = 32'd9; r3 = 32'd9; aop = 3'd0;
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({r1, zf, nf, cf, vf} !== 36'd0) begin
            miscompares++;
            $display("FAIL async_reset: got r1=%h zncv=%b%b%b%b, required all zero",
                     r1, zf, nf, cf, vf);
        end
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (r1 !== 32'd18) begin
            miscompares++;
            $display("FAIL after_reset: got r1=%h, required r1=00000012", r1);
        end
    endtask

    task automatic test_midcycle();
        // inputs changed after the edge must not disturb the captured result
        drive(32'd100, 32'd7, 3'd1, 1'b1);
        r2 = 32'hFFFF_FFFF; r3 = 32'h1; aop = 3'd0;
        #3;
        vectors++;
        if (r1 !== 32'd93 || cf !== 1'b0) begin
            miscompares++;
            $display("FAIL midcycle_stable: got r1=%h cf=%b, required r1=0000005d cf=0", r1, cf);
        end
        r2 = 32'd40; r3 = 32'd2; aop = 3'd0;
        @(posedge clk);
        #1;
        vectors++;
        if (r1 !== 32'd42) begin
            miscompares++;
            $display("FAIL midcycle_last_value: got r1=%h, required r1=0000002a", r1);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic [2:0]  op;
        logic        e;
        logic [35:0] held, want;
        held = {r1, zf, nf, cf, vf};
        for (int i = 0; i < 400; i++) begin
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 4))
                0: a = 32'h7FFF_FFFF;
                1: b = 32'h8000_0000;
                2: b = a;
                default: ;
            endcase
            op = 3'($urandom_range(0, 7));
            e  = ($urandom_range(0, 3) != 0);
            if (e) held = model(a, b, op);
            exp_q.push_back(held);
            drive(a, b, op, e);
            want = exp_q.pop_front();
            vectors++;
            if ({r1, zf, nf, cf, vf} !== want) begin
                miscompares++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h en=%b: got r1=%h zncv=%b%b%b%b, required r1=%h zncv=%b",
                         i, op, a, b, e, r1, zf, nf, cf, vf, want[35:4], want[3:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold_async_reset();
        test_midcycle();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
